dmac_slave_mc: RTL

Multi-channel, parametrised DMAC slave register file. It sits between the bus slave port and `CH` independent DMA engines and their descriptor FIFOs. Per channel, it holds the control, descriptor and interrupt registers, pushes descriptors with full-check and push counting, and tracks a status state machine. It raises one registered, combined interrupt line.

---
 rtl/dmac_slave_mc.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/dmac_slave_mc.sv
// Multi-channel DMAC slave register file: per-channel control/descriptor/interrupt
// registers, descriptor push strobes, status FSMs and one combined interrupt.
module dmac_slave_ch #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [3:0]    off,
    input  logic [31:0]   din,
    input  logic          op_done,
    input  logic          empty,
    input  logic          full,
    output logic [31:0]   rdata,
    output logic          irq,
    output logic          op_start,
    output logic          op_clear,
    output logic [1:0]    op_mode,
    output logic          wr_en,
    output logic [AW-1:0] src,
    output logic [AW-1:0] dst,
    output logic [AW-1:0] size
);
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10, FAULT = 2'b11;

    logic [31:0] start_q, ie_q, src_q, dst_q, size_q, mode_q;
    logic        int_q;
    logic [7:0]  cnt_q;
    logic [1:0]  state_q, state_d;
    logic        done_ev, push, push_ok, wr_start;

    assign done_ev  = op_done && (state_q == BUSY);
    assign push     = we && (off == 4'd6) && din[0];
    assign push_ok  = push && !full;
    assign wr_start = we && (off == 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (done_ev)                state_d = DONE;
        else if (push && full)      state_d = FAULT;
        else if (wr_start && din[0]) state_d = empty ? FAULT : BUSY;
        else if (wr_start)          state_d = IDLE;
    end

    always_comb begin
        op_start = start_q[0];
        op_clear = int_q;
        op_mode  = mode_q[1:0];
        irq      = int_q & ie_q[0];
        case (off)
            4'd0:    rdata = start_q;
            4'd1:    rdata = {31'd0, int_q};
            4'd2:    rdata = ie_q;
            4'd3:    rdata = src_q;
            4'd4:    rdata = dst_q;
            4'd5:    rdata = size_q;
            4'd7:    rdata = mode_q;
            4'd8:    rdata = {30'd0, state_q};
            4'd9:    rdata = {24'd0, cnt_q};
            default: rdata = 32'd0;
        endcase
    end

    // A completion landing on the same edge as a bus write takes precedence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= '0; ie_q <= '0; src_q <= '0; dst_q <= '0;
            size_q <= '0; mode_q <= '0; int_q <= 1'b0; cnt_q <= '0;
        end else begin
            if (we) begin
                case (off)
                    4'd0: start_q <= din;
                    4'd1: if (din[0]) int_q <= 1'b0;
                    4'd2: ie_q   <= din;
                    4'd3: src_q  <= din;
                    4'd4: dst_q  <= din;
                    4'd5: size_q <= din;
                    4'd7: mode_q <= din;
                    default: ;
                endcase
            end
            if (done_ev) begin
                int_q      <= 1'b1;
                start_q[0] <= 1'b0;
            end
            if (push_ok) cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en <= 1'b0; src <= '0; dst <= '0; size <= '0;
        end else begin
            wr_en <= push_ok;
            src   <= push_ok ? src_q[AW-1:0]  : '0;
            dst   <= push_ok ? dst_q[AW-1:0]  : '0;
            size  <= push_ok ? size_q[AW-1:0] : '0;
        end
    end
endmodule

module dmac_slave_mc #(
    parameter int CH = 2,
    parameter int AW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_sel,
    input  logic            s_wr,
    input  logic [15:0]     s_addr,
    input  logic [31:0]     s_din,
    output logic [31:0]     s_dout,
    output logic            s_interrupt,
    input  logic [CH-1:0]   op_done,
    input  logic [CH-1:0]   empty,
    input  logic [CH-1:0]   full,
    output logic [CH-1:0]   op_start,
    output logic [CH-1:0]   op_clear,
    output logic [2*CH-1:0] op_mode,
    output logic [CH-1:0]   wr_en,
    output logic [AW*CH-1:0] source_addr,
    output logic [AW*CH-1:0] dest_addr,
    output logic [AW*CH-1:0] data_size
);
    logic [3:0]              ch_idx, off;
    logic                    bus_wr, bus_rd;
    logic [CH-1:0][31:0]     rdata;
    logic [CH-1:0]           irq;
    logic [CH-1:0][1:0]      mode;
    logic [CH-1:0][AW-1:0]   src, dst, size;
    logic [31:0]             rsel;

    assign ch_idx = s_addr[7:4];
    assign off    = s_addr[3:0];
    assign bus_wr = s_sel && s_wr;
    assign bus_rd = s_sel && !s_wr;

    // Channel indices beyond CH match no instance, so such writes fall away.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        dmac_slave_ch #(.AW(AW)) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .we       (bus_wr && (ch_idx == 4'(c))),
            .off      (off),
            .din      (s_din),
            .op_done  (op_done[c]),
            .empty    (empty[c]),
            .full     (full[c]),
            .rdata    (rdata[c]),
            .irq      (irq[c]),
            .op_start (op_start[c]),
            .op_clear (op_clear[c]),
            .op_mode  (mode[c]),
            .wr_en    (wr_en[c]),
            .src      (src[c]),
            .dst      (dst[c]),
            .size     (size[c])
        );
    end

    assign op_mode     = mode;
    assign source_addr = src;
    assign dest_addr   = dst;
    assign data_size   = size;

    always_comb begin
        rsel = 32'd0;
        for (int c = 0; c < CH; c++)
            if (ch_idx == 4'(c)) rsel = rdata[c];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_dout      <= 32'd0;
            s_interrupt <= 1'b0;
        end else begin
            s_dout      <= bus_rd ? rsel : 32'd0;
            s_interrupt <= |irq;
        end
    end
endmodule
